// File: rtl/sram_ctrl.sv
// Valid/ready front end for an async-strobe SRAM macro.
// Registered CS/WE/OE strobes, split data bus, one-cycle read response.
module sram_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 11,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_cs_b,
  output logic                  sram_we_b,
  output logic                  sram_oe_b,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  sram_data_oe,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] TURN = 2'd3;

  logic [1:0] state;
  logic [3:0] cnt;
  logic       rd_last;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_last      <= 1'b0;
      sram_cs_b    <= 1'b1;
      sram_we_b    <= 1'b1;
      sram_oe_b    <= 1'b1;
      sram_data_oe <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cnt       <= 4'(WAIT_STATES);
            rd_last   <= 1'b0;
            sram_addr <= req_addr;
            sram_cs_b <= 1'b0;
            if (req_we) begin
              state        <= WR;
              sram_wdata   <= req_wdata;
              sram_we_b    <= 1'b0;
              sram_data_oe <= 1'b1;
            end else begin
              state     <= RD;
              sram_oe_b <= 1'b0;
            end
          end
        end
        WR: begin
          if (cnt == 4'd0) begin
            state        <= IDLE;
            sram_cs_b    <= 1'b1;
            sram_we_b    <= 1'b1;
            sram_data_oe <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RD: begin
          // extra cycle after cnt hits 0: SRAM output settles one edge late
          if (rd_last) begin
            state     <= TURN;
            rsp_rdata <= sram_rdata;
            rsp_valid <= 1'b1;
            sram_cs_b <= 1'b1;
            sram_oe_b <= 1'b1;
          end else if (cnt == 4'd0) begin
            rd_last <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        TURN: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: W=0 and W=3 instances,
// each with a small behavioural SRAM on its bus.
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // DUT0: WAIT_STATES = 0
  logic        v0 = 0, we0 = 0;
  logic [10:0] ra0 = '0;
  logic [15:0] wd0 = '0;
  logic        rdy0, rv0, cs0, web0, oeb0, doe0;
  logic [15:0] rd0, sw0, bus0;
  logic [10:0] sa0;
  logic [15:0] m0 [2048];

  sram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst),
    .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_addr(ra0), .req_wdata(wd0),
    .rsp_valid(rv0), .rsp_rdata(rd0),
    .sram_cs_b(cs0), .sram_we_b(web0), .sram_oe_b(oeb0),
    .sram_addr(sa0), .sram_wdata(sw0), .sram_data_oe(doe0),
    .sram_rdata(bus0)
  );

  always @(posedge clk) begin
    if (!cs0 && !web0 && doe0) m0[sa0] <= sw0;
    if (!cs0 && !oeb0) bus0 <= m0[sa0];
  end

  // DUT1: WAIT_STATES = 3
  logic        v1 = 0, we1 = 0;
  logic [10:0] ra1 = '0;
  logic [15:0] wd1 = '0;
  logic        rdy1, rv1, cs1, web1, oeb1, doe1;
  logic [15:0] rd1, sw1, bus1;
  logic [10:0] sa1;
  logic [15:0] m1 [2048];

  sram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_addr(ra1), .req_wdata(wd1),
    .rsp_valid(rv1), .rsp_rdata(rd1),
    .sram_cs_b(cs1), .sram_we_b(web1), .sram_oe_b(oeb1),
    .sram_addr(sa1), .sram_wdata(sw1), .sram_data_oe(doe1),
    .sram_rdata(bus1)
  );

  always @(posedge clk) begin
    if (!cs1 && !web1 && doe1) m1[sa1] <= sw1;
    if (!cs1 && !oeb1) bus1 <= m1[sa1];
  end

  // bus-protocol monitor and response log
  int inv_err = 0;
  int rcnt1 = 0;
  logic p_oeb0 = 1'b1, p_oeb1 = 1'b1;
  logic [15:0] rq[$];

  always @(negedge clk) begin
    if (!web0 && !oeb0) inv_err++;
    if (!web1 && !oeb1) inv_err++;
    if (doe0 && web0) inv_err++;
    if (doe1 && web1) inv_err++;
    if (doe0 && !p_oeb0) inv_err++;
    if (doe1 && !p_oeb1) inv_err++;
    p_oeb0 = oeb0;
    p_oeb1 = oeb1;
    if (rv0) rq.push_back(rd0);
    if (rv1) rcnt1++;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog timeout");
  end

  initial begin
    int n;
    int base;
    int early;
    logic acc;
    int t[4];
    logic w_l[4];
    logic [10:0] a_l[4];
    logic [15:0] d_l[4];

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy0), 1);
    chk("rst_cs", 32'({cs0, web0, oeb0}), 'b111);
    chk("rst_doe", 32'(doe0), 0);
    chk("rst_rsp", 32'(rv0), 0);
    chk("rst_addr", 32'(sa0), 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      step();
      if (!cs0 || !web0 || !oeb0 || doe0 || !rdy0) n++;
    end
    chk("idle_quiet", 32'(n), 0);
    chk("idle_norsp", 32'(rq.size()), 0);

    // W=0 single write then read
    we0 = 1; ra0 = 11'h005; wd0 = 16'hBEEF; v0 = 1;
    step();
    v0 = 0;
    chk("wr_strobe", 32'({cs0, web0, oeb0, doe0}), 'b0011);
    chk("wr_addr", 32'(sa0), 'h005);
    chk("wr_data", 32'(sw0), 'hBEEF);
    chk("wr_busy", 32'(rdy0), 0);
    step();
    chk("wr_end", 32'({cs0, web0, doe0, rdy0}), 'b1101);
    we0 = 0; v0 = 1;
    step();
    v0 = 0;
    chk("rd_strobe", 32'({cs0, web0, oeb0, doe0}), 'b0100);
    step();
    chk("rd_e1_rsp", 32'(rv0), 0);
    chk("rd_e1_oe", 32'(oeb0), 0);
    step();
    chk("rd_rsp", 32'(rv0), 1);
    chk("rd_data", 32'(rd0), 'hBEEF);
    chk("rd_end", 32'({cs0, oeb0, rdy0}), 'b110);
    step();
    chk("rsp_pulse", 32'({rv0, rdy0}), 'b01);

    // W=0 back-to-back with req_valid held
    w_l = '{1'b1, 1'b0, 1'b1, 1'b0};
    a_l = '{11'h000, 11'h000, 11'h7FF, 11'h7FF};
    d_l = '{16'h1234, 16'h0000, 16'hA5A5, 16'h0000};
    base = rq.size();
    for (int i = 0; i < 4; i++) begin
      we0 = w_l[i]; ra0 = a_l[i]; wd0 = d_l[i]; v0 = 1;
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
        acc = rdy0;
        step();
      end
      chk("b2b_accept", 32'(acc), 1);
      t[i] = cyc;
    end
    v0 = 0;
    chk("b2b_w2r", 32'(t[1] - t[0]), 2);
    chk("b2b_r2w", 32'(t[2] - t[1]), 4);
    chk("b2b_w2r2", 32'(t[3] - t[2]), 2);
    repeat (6) step();
    chk("b2b_nrsp", 32'(rq.size() - base), 2);
    if (rq.size() - base == 2) begin
      chk("b2b_rd0", 32'(rq[base]), 'h1234);
      chk("b2b_rd1", 32'(rq[base + 1]), 'hA5A5);
    end

    // read immediately followed by write: turnaround cycle
    we0 = 0; ra0 = 11'h000; v0 = 1;
    step();
    we0 = 1; ra0 = 11'h001; wd0 = 16'h5555;
    step();
    chk("turn_rd2", 32'({oeb0, doe0}), 'b00);
    step();
    chk("turn_bus", 32'({cs0, web0, oeb0, doe0}), 'b1110);
    chk("turn_rsp", 32'({rv0, rdy0}), 'b10);
    chk("turn_data", 32'(rd0), 'h1234);
    step();
    chk("turn_idle", 32'({rdy0, doe0, cs0}), 'b101);
    step();
    v0 = 0;
    chk("turn_wr", 32'({cs0, web0, oeb0, doe0}), 'b0011);
    step();

    // W=3 write then read
    we1 = 1; ra1 = 11'h3FF; wd1 = 16'h0F0F; v1 = 1;
    step();
    v1 = 0;
    chk("w3_wr_doe", 32'(doe1), 1);
    n = 0;
    while (!web1 && n < 20) begin
      n++;
      step();
    end
    chk("w3_we_len", 32'(n), 4);
    step();
    we1 = 0; v1 = 1;
    step();
    v1 = 0;
    early = rcnt1;
    n = 0;
    while (!oeb1 && n < 20) begin
      n++;
      step();
    end
    chk("w3_oe_len", 32'(n), 5);
    chk("w3_noearly", 32'(rcnt1 - early), 0);
    chk("w3_rsp", 32'(rv1), 1);
    chk("w3_data", 32'(rd1), 'h0F0F);
    step();
    chk("w3_rsp_end", 32'({rv1, rdy1}), 'b01);

    // reset in the middle of a read
    we0 = 1; ra0 = 11'h0AA; wd0 = 16'h1111; v0 = 1;
    step();
    v0 = 0;
    step();
    base = rq.size();
    we0 = 0; v0 = 1;
    step();
    v0 = 0;
    chk("mid_rd_oe", 32'(oeb0), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rd_rst", 32'({cs0, oeb0, rv0, rdy0}), 'b1101);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) step();
    chk("mid_rd_norsp", 32'(rq.size() - base), 0);

    // reset in the first WR cycle, before the commit edge
    we0 = 1; wd0 = 16'h2222; v0 = 1;
    step();
    v0 = 0;
    chk("mid_wr_we", 32'(web0), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_wr_rst", 32'({cs0, web0, doe0}), 'b110);
    @(negedge clk);
    rst = 1'b0;
    step();
    we0 = 0; v0 = 1;
    step();
    v0 = 0;
    step();
    step();
    chk("mid_wr_rsp", 32'(rv0), 1);
    chk("mid_wr_old", 32'(rd0), 'h1111);
    repeat (3) step();

    chk("rsp_total", 32'(rq.size()), 5);
    chk("invariants", 32'(inv_err), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
